// File: rtl/sejf_pkg.sv
// Shared constants for the safe-dial logic: dial geometry, combination digits and the
// quadrature phase order, plus a helper that classifies a transition between two phases.
package sejf_pkg;

    localparam int DIAL_MAX   = 40;
    localparam int COMBO0     = 10;
    localparam int COMBO1     = 25;
    localparam int COMBO2     = 3;
    localparam int DEB_CYCLES = 16;

    // Clockwise order of the {a,b} pair; walking it backwards is a down step.
    localparam logic [1:0] QUAD_UP_SEQ0 = 2'b00;
    localparam logic [1:0] QUAD_UP_SEQ1 = 2'b01;
    localparam logic [1:0] QUAD_UP_SEQ2 = 2'b11;
    localparam logic [1:0] QUAD_UP_SEQ3 = 2'b10;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_ERR
    } step_e;

    function automatic logic [1:0] quad_phase(input logic [1:0] ab);
        logic [1:0] ph;
        ph = 2'd0;
        case (ab)
            QUAD_UP_SEQ0: ph = 2'd0;
            QUAD_UP_SEQ1: ph = 2'd1;
            QUAD_UP_SEQ2: ph = 2'd2;
            QUAD_UP_SEQ3: ph = 2'd3;
            default:      ph = 2'd0;
        endcase
        return ph;
    endfunction

    function automatic step_e quad_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] prev_next;
        logic [1:0] cur_next;
        step_e      st;
        prev_next = quad_phase(prev_ab) + 2'd1;
        cur_next  = quad_phase(cur_ab) + 2'd1;
        if (prev_ab == cur_ab) begin
            st = STEP_NONE;
        end else if (quad_phase(cur_ab) == prev_next) begin
            st = STEP_UP;
        end else if (quad_phase(prev_ab) == cur_next) begin
            st = STEP_DOWN;
        end else begin
            st = STEP_ERR;
        end
        return st;
    endfunction

endpackage

// File: rtl/dial_tracker_debounce.sv
// One quadrature channel: two-flop synchronizer followed by a stable-level filter that
// only accepts a new level after it has persisted for DEB_CYCLES consecutive cycles.
module debounce #(
    parameter int DEB_CYCLES = sejf_pkg::DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any cycle where the input agrees with the held level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/dial_tracker.sv
// Safe dial tracker: debounces the quadrature pair, decodes steps into a wrapping
// position with direction-change detection, and compares the position to a combo digit.
module dial_tracker #(
    parameter int DIAL_MAX   = sejf_pkg::DIAL_MAX,
    parameter int DEB_CYCLES = sejf_pkg::DEB_CYCLES,
    parameter int COMBO0     = sejf_pkg::COMBO0,
    parameter int COMBO1     = sejf_pkg::COMBO1,
    parameter int COMBO2     = sejf_pkg::COMBO2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       qa,
    input  logic       qb,
    input  logic       clrCount,
    input  logic [1:0] sel,
    output logic [5:0] pos,
    output logic       cnten,
    output logic       up,
    output logic       dirch,
    output logic       eq,
    output logic       qerr
);
    import sejf_pkg::*;

    localparam logic [5:0] POS_LAST = 6'(DIAL_MAX - 1);
    localparam logic [5:0] DIGIT0   = 6'(COMBO0);
    localparam logic [5:0] DIGIT1   = 6'(COMBO1);
    localparam logic [5:0] DIGIT2   = 6'(COMBO2);

    logic [1:0] raw_pair;
    logic [1:0] deb_pair;
    logic [1:0] prev_q;
    logic [5:0] pos_q,     pos_d;
    logic       up_q,      up_d;
    logic       has_dir_q, has_dir_d;
    logic       cnten_q,   cnten_d;
    logic       dirch_q,   dirch_d;
    logic       qerr_q,    qerr_d;
    step_e      step;

    assign raw_pair = {qa, qb};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk    (clk),
                .rst    (rst),
                .raw_i  (raw_pair[gi]),
                .level_o(deb_pair[gi])
            );
        end
    endgenerate

    assign step = quad_step(prev_q, deb_pair);

    // Clear wins over any step decoded in the same cycle; the pair history still advances.
    always_comb begin
        pos_d     = pos_q;
        up_d      = up_q;
        has_dir_d = has_dir_q;
        cnten_d   = 1'b0;
        dirch_d   = 1'b0;
        qerr_d    = 1'b0;
        if (clrCount) begin
            pos_d     = '0;
            up_d      = 1'b0;
            has_dir_d = 1'b0;
        end else begin
            unique case (step)
                STEP_UP: begin
                    pos_d     = (pos_q == POS_LAST) ? 6'd0 : pos_q + 6'd1;
                    up_d      = 1'b1;
                    has_dir_d = 1'b1;
                    cnten_d   = 1'b1;
                    dirch_d   = has_dir_q & ~up_q;
                end
                STEP_DOWN: begin
                    pos_d     = (pos_q == 6'd0) ? POS_LAST : pos_q - 6'd1;
                    up_d      = 1'b0;
                    has_dir_d = 1'b1;
                    cnten_d   = 1'b1;
                    dirch_d   = has_dir_q & up_q;
                end
                STEP_ERR:  qerr_d = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= 2'b00;
            pos_q     <= '0;
            up_q      <= 1'b0;
            has_dir_q <= 1'b0;
            cnten_q   <= 1'b0;
            dirch_q   <= 1'b0;
            qerr_q    <= 1'b0;
        end else begin
            prev_q    <= deb_pair;
            pos_q     <= pos_d;
            up_q      <= up_d;
            has_dir_q <= has_dir_d;
            cnten_q   <= cnten_d;
            dirch_q   <= dirch_d;
            qerr_q    <= qerr_d;
        end
    end

    always_comb begin
        eq = 1'b0;
        case (sel)
            2'd0:    eq = (pos_q == DIGIT0);
            2'd1:    eq = (pos_q == DIGIT1);
            2'd2:    eq = (pos_q == DIGIT2);
            default: eq = 1'b0;
        endcase
    end

    assign pos   = pos_q;
    assign up    = up_q;
    assign cnten = cnten_q;
    assign dirch = dirch_q;
    assign qerr  = qerr_q;

endmodule

// File: doc/dial_tracker.md
DIAL_TRACKER -- requirements
Module: dial_tracker

Interface
REQ-001 Parameter DIAL_MAX, default 40, number of dial positions (position range 0..DIAL_MAX-1).
REQ-002 Parameter DEB_CYCLES, default 16, consecutive stable cycles required to accept a new debounced level.
REQ-003 Parameters COMBO0, COMBO1, COMBO2, defaults 10, 25, 3, the three combination digits.
REQ-004 clk  in  1  system clock; the block uses one clock, and all registers are updated on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 qa, qb  in  1 each  raw quadrature channels from the dial; these are asynchronous and bouncy.
REQ-007 clrCount  in  1  level; clears the position and direction history.
REQ-008 sel  in  2  selects the digit to compare: 0=COMBO0, 1=COMBO1, 2=COMBO2, 3=none.
REQ-009 pos  out  6  current dial position.
REQ-010 cnten  out  1  one-cycle pulse per accepted step.
REQ-011 up  out  1  direction of the last accepted step (1=increment/clockwise).
REQ-012 dirch  out  1  one-cycle pulse when a step's direction differs from the previous step's direction.
REQ-013 eq  out  1  pos equals the selected digit.
REQ-014 qerr  out  1  one-cycle pulse on an illegal quadrature transition.

Function
REQ-015 qa and qb SHALL each pass through a 2-flop synchronizer before any other logic.
REQ-016 Each synchronized channel SHALL update its debounced level only after differing from that level for DEB_CYCLES consecutive cycles; any intermediate match restarts the count.
REQ-017 The decoder SHALL compare the current and previous debounced pair {a,b}: 00->01->11->10->00 is an up step; the reverse sequence is a down step.
REQ-018 A change of both bits in the same cycle SHALL pulse qerr, leave pos, up and dirch unchanged, not pulse cnten, and adopt the new pair as the previous pair.
REQ-019 On an up step, pos SHALL increment, wrapping DIAL_MAX-1 -> 0.
REQ-020 On a down step, pos SHALL decrement, wrapping 0 -> DIAL_MAX-1.
REQ-021 pos, up, cnten and dirch SHALL be registered and update in the same cycle, one cycle after the debounced pair changes.
REQ-022 Total latency from a clean pin edge to cnten SHALL be DEB_CYCLES+3 cycles.
REQ-023 A has_dir flag SHALL be set by the first accepted step after reset or clear.
REQ-024 dirch SHALL pulse only when has_dir=1 and the new direction differs from up; the first step after a clear never pulses dirch.
REQ-025 eq SHALL be combinational from registered pos and sel, and SHALL be 0 when sel=3.
REQ-026 While clrCount=1: pos=0, has_dir=0, up=0, and no cnten, dirch or qerr pulse is issued; synchronizers and debouncers keep running.
REQ-027 A step coincident with clrCount=1 SHALL be discarded, with the clear taking priority.
REQ-028 A step in the cycle clrCount falls SHALL be accepted normally.

Reset
REQ-029 rst SHALL set pos=0, up=0, has_dir=0, cnten=0, dirch=0 and qerr=0.
REQ-030 rst SHALL set the synchronizer flops, debounced levels and previous pair to 0, and clear the debounce counters.
REQ-031 rst asserted mid-debounce or mid-step SHALL abort it, and no pulse SHALL issue in the following cycle.

Structure
REQ-032 Package sejf_pkg SHALL hold DIAL_MAX, COMBO0..2, the DEB_CYCLES default and the quadrature up-sequence constants, shared with master_fsm.
REQ-033 One sub-module, debounce (synchronizer plus stable counter, parameter DEB_CYCLES), SHALL be instanced once per channel.
REQ-034 Decoder, position counter, direction history and comparator SHALL live in dial_tracker.

Verification (DEB_CYCLES=4)
REQ-035 After rst, drive a clean up sequence 00->01->11->10->00 with each pair held 10 cycles -> 4 cnten pulses, pos 0->4, up=1, no dirch, and first cnten DEB_CYCLES+3=7 cycles after the first edge.
REQ-036 From pos=0 drive one down step -> pos=39, up=0, dirch=0; continue from pos=39 with one up step -> pos=0, dirch pulses once.
REQ-037 Glitch qa high for 2 cycles -> no cnten and pos unchanged; hold qa high 6 cycles -> exactly one cnten.
REQ-038 Drive qa and qb 00->11 simultaneously and stably -> one qerr pulse, no cnten, pos unchanged.
REQ-039 Step to pos=10 with sel=0 -> eq=1; set sel=1 -> eq=0; set sel=3 -> eq=0.
REQ-040 Assert clrCount at pos=17 in the same cycle a step completes -> pos=0, no cnten; the next opposite-direction step -> dirch=0.
